// File: rtl/cpu6_idstage.sv
// CPU6 decode stage: classifies each fetched instruction, decodes its immediate,
// and holds up to two decoded entries in an in-order skid buffer toward execute.
`ifndef CPU6_XLEN
`define CPU6_XLEN 32
`endif
`ifndef CPU6_IMMTYPE_NONE
`define CPU6_IMMTYPE_NONE 3'd0
`define CPU6_IMMTYPE_I    3'd1
`define CPU6_IMMTYPE_S    3'd2
`define CPU6_IMMTYPE_B    3'd3
`define CPU6_IMMTYPE_U    3'd4
`define CPU6_IMMTYPE_J    3'd5
`endif

module cpu6_immdec (
  input  logic [`CPU6_XLEN-1:0] instr,
  input  logic [2:0]            immtype,
  output logic [`CPU6_XLEN-1:0] imm
);
  // Opcode bits carry no immediate information.
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  always_comb begin
    imm = '0;
    case (immtype)
      `CPU6_IMMTYPE_I: imm = {{20{instr[31]}}, instr[31:20]};
      `CPU6_IMMTYPE_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      `CPU6_IMMTYPE_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      `CPU6_IMMTYPE_U: imm = {instr[31:12], 12'd0};
      default:         imm = '0;
    endcase
  end
endmodule

module cpu6_idstage (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_valid,
  input  logic [`CPU6_XLEN-1:0] if_instr,
  input  logic [`CPU6_XLEN-1:0] if_pc,
  output logic                  if_ready,
  input  logic                  flush,
  output logic                  id_valid,
  input  logic                  ex_ready,
  output logic [`CPU6_XLEN-1:0] id_instr,
  output logic [`CPU6_XLEN-1:0] id_pc,
  output logic [`CPU6_XLEN-1:0] id_imm,
  output logic [2:0]            id_immtype,
  output logic                  id_illegal
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;

  typedef struct packed {
    logic [`CPU6_XLEN-1:0] instr;
    logic [`CPU6_XLEN-1:0] pc;
    logic [`CPU6_XLEN-1:0] imm;
    logic [2:0]            immtype;
    logic                  illegal;
  } entry_t;

  state_e state_q, state_d;
  entry_t head_q, head_d, tail_q, tail_d, in_ent;
  logic   if_ready_q, if_ready_d;
  logic   push, pop;

  logic [2:0]            dec_type;
  logic                  dec_illegal;
  logic [`CPU6_XLEN-1:0] dec_imm, j_imm, in_imm;

  always_comb begin
    dec_type    = `CPU6_IMMTYPE_NONE;
    dec_illegal = 1'b0;
    if (if_instr[1:0] != 2'b11) begin
      dec_illegal = 1'b1;
    end else begin
      case (if_instr[6:0])
        7'b0000011, 7'b0010011, 7'b1100111,
        7'b1110011, 7'b0001111:               dec_type = `CPU6_IMMTYPE_I;
        7'b0100011:                           dec_type = `CPU6_IMMTYPE_S;
        7'b1100011:                           dec_type = `CPU6_IMMTYPE_B;
        7'b0110111, 7'b0010111:               dec_type = `CPU6_IMMTYPE_U;
        7'b1101111:                           dec_type = `CPU6_IMMTYPE_J;
        7'b0110011:                           dec_type = `CPU6_IMMTYPE_NONE;
        default:                              dec_illegal = 1'b1;
      endcase
    end
  end

  cpu6_immdec u_immdec (
    .instr   (if_instr),
    .immtype (dec_type),
    .imm     (dec_imm)
  );

  // The shared decoder has no J format, so jal's immediate is assembled here.
  assign j_imm  = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20],
                   if_instr[30:21], 1'b0};
  assign in_imm = (dec_type == `CPU6_IMMTYPE_J) ? j_imm : dec_imm;
  assign in_ent = {if_instr, if_pc, in_imm, dec_type, dec_illegal};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      if_ready_q <= 1'b1;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      if_ready_q <= if_ready_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (push) state_d = ONE;
        ONE: begin
          if (push && !pop)      state_d = TWO;
          else if (!push && pop) state_d = EMPTY;
        end
        TWO:     if (pop && !push) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    id_valid   = (state_q != EMPTY);
    push       = if_valid & if_ready_q;
    pop        = id_valid & ex_ready;
    // Ready is precomputed from the next state so it never depends on ex_ready combinationally.
    if_ready_d = (state_d != TWO);
    if_ready   = if_ready_q;
    id_instr   = head_q.instr;
    id_pc      = head_q.pc;
    id_imm     = head_q.imm;
    id_immtype = head_q.immtype;
    id_illegal = head_q.illegal;
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    case (state_q)
      EMPTY: if (push) head_d = in_ent;
      ONE: begin
        if (push && pop) head_d = in_ent;
        else if (push)   tail_d = in_ent;
      end
      TWO: begin
        if (pop) begin
          head_d = tail_q;
          if (push) tail_d = in_ent;
        end
      end
      default: head_d = head_q;
    endcase
  end
endmodule

// File: tb/tb_cpu6_idstage.sv
// Bench for cpu6_idstage: directed scenarios plus randomized traffic against a queue model.
module tb_cpu6_idstage;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_valid = 1'b0, flush = 1'b0, ex_ready = 1'b0;
  logic [31:0] if_instr = '0, if_pc = '0;
  logic        if_ready, id_valid, id_illegal;
  logic [31:0] id_instr, id_pc, id_imm;
  logic [2:0]  id_immtype;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  ityp;
    logic        ill;
  } ent_t;

  ent_t q[$];

  always #5 clk = ~clk;

  cpu6_idstage dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_ready(if_ready), .flush(flush), .id_valid(id_valid), .ex_ready(ex_ready),
    .id_instr(id_instr), .id_pc(id_pc), .id_imm(id_imm), .id_immtype(id_immtype),
    .id_illegal(id_illegal)
  );

  function automatic logic signed [31:0] asr(input logic signed [31:0] v, input int n);
    return v >>> n;
  endfunction

  // Reference decode: immediates built arithmetically from the field placements.
  function automatic ent_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    ent_t e;
    logic signed [31:0] s;
    s = ins;
    e.instr = ins; e.pc = pc; e.imm = '0; e.ityp = 3'd0; e.ill = 1'b0;
    if (ins[1:0] != 2'b11) e.ill = 1'b1;
    else case (ins[6:0])
      7'h03, 7'h13, 7'h67, 7'h73, 7'h0F: begin e.ityp = 3'd1; e.imm = asr(s, 20); end
      7'h23: begin
        e.ityp = 3'd2;
        e.imm  = (asr(s, 20) & ~32'h1F) | 32'(ins[11:7]);
      end
      7'h63: begin
        e.ityp = 3'd3;
        e.imm  = (asr(s, 19) & 32'hFFFF_F000) | (32'(ins[7]) << 11)
               | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
      end
      7'h37, 7'h17: begin e.ityp = 3'd4; e.imm = ins & 32'hFFFF_F000; end
      7'h6F: begin
        e.ityp = 3'd5;
        e.imm  = (asr(s, 11) & 32'hFFF0_0000) | (32'(ins[19:12]) << 12)
               | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
      end
      7'h33: e.ityp = 3'd0;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [101:0] exp_vec();
    ent_t h;
    h = '0;
    if (q.size() > 0) h = q[0];
    return {q.size() < 2, q.size() > 0, h};
  endfunction

  function automatic logic [101:0] obs_vec();
    return {if_ready, id_valid,
            id_valid ? {id_instr, id_pc, id_imm, id_immtype, id_illegal} : 100'd0};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  ops [12];
    ops = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};
    w = $urandom;
    if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 11)];
    return w;
  endfunction

  // Advance one clock, updating the model from the inputs present at the edge.
  task automatic tick();
    bit   acc, rel;
    ent_t e;
    acc = if_valid && (q.size() < 2);
    rel = (q.size() > 0) && ex_ready;
    e   = ref_decode(if_instr, if_pc);
    @(posedge clk);
    if (reset || flush) q.delete();
    else begin
      if (rel) q.delete(0);
      if (acc) q.push_back(e);
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({if_ready, id_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_ctrl: got ready/valid %b required 10", {if_ready, id_valid});
    end
    vectors++;
    if ({id_instr, id_pc, id_imm, id_immtype, id_illegal} !== 100'd0) begin
      miscompares++;
      $display("FAIL reset_data: got %h required 0", {id_instr, id_pc, id_imm, id_immtype, id_illegal});
    end
    reset = 1'b0;
    q.delete();
  endtask

  task automatic test_addi();
    ex_ready = 1'b1; if_valid = 1'b1; if_instr = 32'hFFF0_0093; if_pc = 32'h100;
    tick();
    if_valid = 1'b0;
    vectors++;
    if ({id_valid, id_imm, id_immtype, id_illegal, id_pc} !== {1'b1, 32'hFFFF_FFFF, 3'd1, 1'b0, 32'h100}) begin
      miscompares++;
      $display("FAIL addi: got v=%b imm=%h t=%0d ill=%b pc=%h required 1 ffffffff 1 0 100",
               id_valid, id_imm, id_immtype, id_illegal, id_pc);
    end
    tick();
    vectors++;
    if (id_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL addi_drain: got id_valid %b required 0", id_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins [3];
    logic [31:0] imm [3];
    logic [2:0]  typ [3];
    ins = '{32'hFE11_2E23, 32'h1234_52B7, 32'hFF9F_F06F};
    imm = '{32'hFFFF_FFFC, 32'h1234_5000, 32'hFFFF_FFF8};
    typ = '{3'd2, 3'd4, 3'd5};
    ex_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if_valid = 1'b1; if_instr = ins[k]; if_pc = 32'h200 + 32'(k * 4);
      tick();
      vectors++;
      if ({id_valid, id_instr, id_imm, id_immtype} !== {1'b1, ins[k], imm[k], typ[k]}) begin
        miscompares++;
        $display("FAIL b2b[%0d]: got v=%b ins=%h imm=%h t=%0d required 1 %h %h %0d",
                 k, id_valid, id_instr, id_imm, id_immtype, ins[k], imm[k], typ[k]);
      end
    end
    if_valid = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    logic [31:0] st [3];
    logic [31:0] got [$];
    int k;
    bit acc;
    st = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193};
    k = 0; ex_ready = 1'b0; if_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      if_instr = st[k]; if_pc = 32'h300 + 32'(k * 4);
      acc = if_ready;
      tick();
      if (acc) k++;
    end
    if_instr = st[2]; if_pc = 32'h308;
    vectors++;
    if ({if_ready, 2'(k)} !== {1'b0, 2'd2}) begin
      miscompares++;
      $display("FAIL stall_full: got if_ready=%b accepted=%0d required 0 2", if_ready, k);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if ({id_valid, id_instr, if_ready} !== {1'b1, st[0], 1'b0}) begin
        miscompares++;
        $display("FAIL stall_hold: got v=%b ins=%h rdy=%b required 1 %h 0",
                 id_valid, id_instr, if_ready, st[0]);
      end
    end
    ex_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (id_valid) got.push_back(id_instr);
      if (k < 3) begin if_valid = 1'b1; if_instr = st[k]; if_pc = 32'h300 + 32'(k * 4); end
      else if_valid = 1'b0;
      acc = if_ready && if_valid;
      tick();
      if (acc) k++;
    end
    vectors++;
    if (got.size() != 3 || got[0] !== st[0] || got[1] !== st[1] || got[2] !== st[2]) begin
      miscompares++;
      $display("FAIL stall_order: got %0d entries required 3 in order %h %h %h",
               got.size(), st[0], st[1], st[2]);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] ins [2];
    ins = '{32'h0000_007F, 32'h0000_0000};
    ex_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if_valid = 1'b1; if_instr = ins[k]; if_pc = 32'h400 + 32'(k * 4);
      tick();
      vectors++;
      if ({id_valid, id_instr, id_illegal, id_imm, id_immtype} !== {1'b1, ins[k], 1'b1, 32'd0, 3'd0}) begin
        miscompares++;
        $display("FAIL illegal[%0d]: got v=%b ins=%h ill=%b imm=%h t=%0d required 1 %h 1 0 0",
                 k, id_valid, id_instr, id_illegal, id_imm, id_immtype, ins[k]);
      end
    end
    if_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    ex_ready = 1'b0; if_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if_instr = 32'h0050_0093 + 32'(k << 20); if_pc = 32'h500 + 32'(k * 4);
      tick();
    end
    flush = 1'b1; if_instr = 32'h0770_0093; if_pc = 32'h508;
    tick();
    flush = 1'b0; if_valid = 1'b0;
    vectors++;
    if ({id_valid, if_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL flush_two: got valid/ready %b required 01", {id_valid, if_ready});
    end
    // Flush while an instruction is actually handshaken from ONE.
    if_valid = 1'b1; if_instr = 32'h0010_0093; if_pc = 32'h600;
    tick();
    flush = 1'b1; if_instr = 32'h0990_0093; if_pc = 32'h604;
    tick();
    flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if ({id_valid, if_ready} !== 2'b01) begin
        miscompares++;
        $display("FAIL flush_discard[%0d]: got valid/ready %b required 01", c, {id_valid, if_ready});
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    ex_ready = 1'b0; if_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if_instr = 32'h0010_0093 + 32'(k << 20); if_pc = 32'h700 + 32'(k * 4);
      tick();
    end
    if_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({id_valid, if_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL async_reset: got valid/ready %b required 01 before edge", {id_valid, if_ready});
    end
    q.delete();
    #1 reset = 1'b0;
    if_valid = 1'b1; if_instr = 32'h0230_0093; if_pc = 32'h800; ex_ready = 1'b1;
    tick();
    if_valid = 1'b0;
    vectors++;
    if ({id_valid, id_instr, id_pc, id_imm} !== {1'b1, 32'h0230_0093, 32'h800, 32'h23}) begin
      miscompares++;
      $display("FAIL post_reset_push: got v=%b ins=%h pc=%h imm=%h required 1 00230093 800 23",
               id_valid, id_instr, id_pc, id_imm);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      if_valid = ($urandom_range(0, 3) != 0);
      if_instr = rand_instr();
      if_pc    = $urandom;
      ex_ready = ($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 24) == 0);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random[%0d]: got %h required %h", i, obs_vec(), exp_vec());
      end
      tick();
    end
    flush = 1'b0; if_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_flush();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cpu6_idstage.md
CPU6_IDSTAGE -- requirements
Module: cpu6_idstage

Interface
REQ-001 Parameter: none; data width SHALL be `CPU6_XLEN (32) throughout.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 if_valid  input  1  fetch presents an instruction.
REQ-005 if_instr  input  32  instruction word.
REQ-006 if_pc  input  32  PC of if_instr.
REQ-007 if_ready  output  1  stage can accept; transfer when if_valid & if_ready.
REQ-008 flush  input  1  discard all buffered and incoming instructions.
REQ-009 id_valid  output  1  head entry valid toward execute.
REQ-010 ex_ready  input  1  execute accepts; transfer when id_valid & ex_ready.
REQ-011 id_instr  output  32  head instruction.
REQ-012 id_pc  output  32  head PC.
REQ-013 id_imm  output  32  head sign-extended immediate.
REQ-014 id_immtype  output  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J.
REQ-015 id_illegal  output  1  head opcode unrecognised.

Function
REQ-016 The block SHALL instantiate cpu6_immdec for I/S/B/U immediates, driving its immtype with the matching `CPU6_IMMTYPE_* code.
REQ-017 J immediate SHALL be generated locally: {11 copies of instr[31], instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
REQ-018 Opcode classification (instr[6:0]): 0000011, 0010011, 1100111, 1110011, 0001111 -> I; 0100011 -> S; 1100011 -> B; 0110111, 0010111 -> U; 1101111 -> J; 0110011 -> NONE, imm 0.
REQ-019 Any other opcode, or instr[1:0] != 2'b11, SHALL give immtype NONE, imm 0, illegal 1; it is still buffered and forwarded, never dropped.
REQ-020 Classification and immediate decode SHALL occur combinationally on if_instr at acceptance; buffered entries store instr, pc, imm, immtype, illegal.
REQ-021 Storage SHALL be a 2-entry in-order skid buffer; state machine EMPTY (0 entries), ONE, TWO.
REQ-022 Transitions: accept only -> count+1; release only -> count-1; accept and release same cycle -> count unchanged; neither -> unchanged.
REQ-023 if_ready SHALL be a registered output, 1 in EMPTY and ONE, 0 in TWO; no combinational path from ex_ready to if_ready.
REQ-024 id_valid SHALL be 1 exactly in ONE and TWO; id_* outputs SHALL reflect the oldest entry.
REQ-025 Latency: instruction accepted in cycle N SHALL appear on id_* in cycle N+1 if buffer was EMPTY or the head is released in N.
REQ-026 While id_valid=1 and ex_ready=0, id_* SHALL hold stable.
REQ-027 In TWO with ex_ready=1 and no flush, the second entry SHALL move to head and state SHALL go to ONE; if_ready SHALL be 1 next cycle.
REQ-028 flush=1 SHALL force state EMPTY next cycle, overriding accept and release; an instruction handshaken in the flush cycle SHALL be discarded.
REQ-029 With flush=1 the block SHALL still assert if_ready per its current registered value; id_valid SHALL be 0 from the next cycle.
REQ-030 Invalid entries' data fields are don't-care but SHALL not cause X on id_valid or if_ready.

Reset
REQ-031 On reset assertion, immediately and asynchronously: state EMPTY, id_valid 0, if_ready 1, id_instr/id_pc/id_imm 0, id_immtype 0, id_illegal 0.
REQ-032 Reset asserted mid-operation SHALL drop all buffered entries; first acceptance is possible in the first clock after deassertion.

Verification
REQ-033 EMPTY, ex_ready=1, push 0xFFF00093 (addi x1,x0,-1) -> next cycle id_valid 1, id_imm 0xFFFFFFFF, id_immtype 1, id_illegal 0.
REQ-034 Push 0xFE112E23 (sw), then 0x123452B7 (lui), then 0xFF9FF06F (jal -8), back-to-back -> imm 0xFFFFFFFC/S, 0x12345000/U, 0xFFFFFFF8/J, in order, one per cycle.
REQ-035 ex_ready=0, offer three instructions continuously -> first two accepted, if_ready 0 after second, third held; raise ex_ready -> all three emerge in order, none lost or duplicated.
REQ-036 Push 0x0000007F and 0x00000000 -> both forwarded with id_illegal 1, id_imm 0, id_immtype 0.
REQ-037 State TWO, assert flush with if_valid=1 -> next cycle id_valid 0, if_ready 1, the incoming instruction never appears.
REQ-038 State TWO, assert reset asynchronously between clock edges -> id_valid 0 and if_ready 1 before the next edge; after deassertion a push emerges one cycle later.
